// File: rtl/led_code_sequencer.sv
// led_code_sequencer: flashes i+1 LED pulses for each latched request from source i, round-robin.
module led_code_sequencer #(
  parameter int PRESCALE  = 1000000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       force_on,
  output logic       led,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  state_t state, state_n;
  logic [23:0] pre;
  logic [7:0] tcnt;
  logic [2:0] pulses, pulses_n;
  logic [3:0] req_q, pending, clr;
  logic [1:0] last_id, last_n, id_n, grant;
  logic tick, done_n;
  assign tick = pre == 24'(PRESCALE - 1);
  assign busy = state != IDLE;
  // Descending scan so the nearest pending source after last_id wins.
  always_comb begin
    grant = last_id;
    for (int k = 4; k > 0; k--)
      if (pending[last_id + 2'(k)]) grant = last_id + 2'(k);
  end
  always_comb begin
    state_n  = state;
    pulses_n = pulses;
    id_n     = active_id;
    last_n   = last_id;
    clr      = '0;
    done_n   = 1'b0;
    if (!en) state_n = IDLE;
    else if (tick)
      case (state)
        IDLE: if (|pending) begin
          state_n  = ON;
          id_n     = grant;
          pulses_n = 3'(grant) + 3'd1;
        end
        ON: if (tcnt == 8'(ON_TICKS - 1)) begin
          state_n  = OFF;
          pulses_n = pulses - 3'(pulses != 3'd0);
        end
        OFF: if (tcnt == 8'(OFF_TICKS - 1)) state_n = pulses != 3'd0 ? ON : GAP;
        GAP: if (tcnt == 8'(GAP_TICKS - 1)) begin
          state_n        = IDLE;
          done_n         = 1'b1;
          clr[active_id] = 1'b1;
          last_n         = active_id;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      led       <= 1'b0;
      done      <= 1'b0;
      active_id <= 2'd0;
      last_id   <= 2'd3;
      pending   <= '0;
      pre       <= '0;
      tcnt      <= '0;
      pulses    <= '0;
      req_q     <= '0;
    end else begin
      state     <= state_n;
      led       <= force_on | (state_n == ON);
      done      <= done_n;
      active_id <= id_n;
      last_id   <= last_n;
      pending   <= (pending & ~clr) | (req & ~req_q);
      pre       <= tick ? '0 : pre + 24'd1;
      tcnt      <= state_n != state ? '0 : tcnt + 8'(tick);
      pulses    <= pulses_n;
      req_q     <= req;
    end
endmodule

// File: tb/tb_led_code_sequencer.sv
// tb_led_code_sequencer: randomized and directed checks against a segment-list model of the LED codes.
module tb_led_code_sequencer;
  localparam int P = 4, ON = 2, OFF = 2, GAP = 8;
  logic clk = 0, rst = 1, en = 1, force_on = 0;
  logic [3:0] req = 0;
  logic led, busy, done;
  logic [1:0] active_id;
  int total = 0, bad = 0, cyc = 0, nled = 0, ndone = 0, dcyc = 0;
  int dq[$];

  led_code_sequencer #(.PRESCALE(P), .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .force_on(force_on),
    .led(led), .busy(busy), .active_id(active_id), .done(done));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, exp);
    end
  endtask

  // A code is a list of segments: ON,OFF repeated id+1 times, then GAP.
  int m_pre, m_seg, m_left, m_id, m_last;
  logic [3:0] m_pend, m_reqq, m_rise, m_clr;
  bit m_busy, m_led, m_done, m_tick, m_found;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pre = 0; m_pend = 0; m_reqq = 0; m_busy = 0; m_led = 0; m_done = 0;
      m_id = 0; m_last = 3; m_seg = 0; m_left = 0;
    end else begin
      m_tick = m_pre == P - 1;
      m_pre = m_tick ? 0 : m_pre + 1;
      m_rise = req & ~m_reqq;
      m_reqq = req;
      m_clr = 0;
      m_done = 0;
      if (!en) m_busy = 0;
      else if (m_tick) begin
        if (!m_busy) begin
          m_found = 0;
          for (int k = 1; k <= 4; k++)
            if (!m_found && m_pend[(m_last + k) % 4]) begin
              m_found = 1;
              m_id = (m_last + k) % 4;
            end
          if (m_found) begin m_busy = 1; m_seg = 0; m_left = ON; end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_seg++;
            if (m_seg == 2 * (m_id + 1) + 1) begin
              m_busy = 0; m_done = 1; m_clr[m_id] = 1; m_last = m_id;
            end else
              m_left = m_seg == 2 * (m_id + 1) ? GAP : (m_seg % 2 == 1 ? OFF : ON);
          end
        end
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      m_led = force_on | (m_busy && m_seg % 2 == 0 && m_seg < 2 * (m_id + 1));
    end
  end

  always @(negedge clk) begin
    check("led", led, m_led);
    check("busy", busy, m_busy);
    check("active_id", active_id, m_id);
    check("done", done, m_done);
    cyc++;
    if (led) nled++;
    if (done) begin ndone++; dcyc = cyc; dq.push_back(active_id); end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    cyc = 0; nled = 0; ndone = 0; dcyc = 0; dq.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    clear_counts();
    rst = 0;
  endtask

  task automatic pulse_req(logic [3:0] r);
    req = r;
    step(1);
    req = 0;
  endtask

  task automatic wait_led(int lim);
    int i = 0;
    while (led !== 1'b1 && i < lim) begin step(1); i++; end
    check("wait_led", led, 1);
  endtask

  task automatic run_single(bit frc, output int dc, output int nl, output int nd, output int id0);
    en = 1; force_on = 0; req = 0;
    do_reset();
    step(3);
    pulse_req(4'b0010);
    repeat (200) begin
      force_on = frc && busy && !m_led ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1);
    end
    force_on = 0;
    dc = dcyc; nl = nled; nd = ndone; id0 = dq.size() > 0 ? dq[0] : -1;
  endtask

  initial begin
    int dc0, nl0, nd0, id0, dc1, nl1, nd1, id1;
    step(1);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_id", active_id, 0);

    run_single(0, dc0, nl0, nd0, id0);
    check("single_led_cycles", nl0, 16);
    check("single_done_count", nd0, 1);
    check("single_id", id0, 1);
    run_single(1, dc1, nl1, nd1, id1);
    check("force_done_time", dc1, dc0);
    check("force_done_count", nd1, 1);

    rst = 1; req = 4'b1111;
    step(2);
    clear_counts();
    rst = 0;
    step(400);
    req = 0;
    check("all_done_count", ndone, 4);
    for (int i = 0; i < 4; i++) check("all_order", dq.size() > i ? dq[i] : -1, i);
    check("all_led_cycles", nled, 80);

    do_reset();
    pulse_req(4'b0100);
    begin
      int i = 0;
      while (busy !== 1'b1 && i < 50) begin step(1); i++; end
      check("wait_busy", busy, 1);
    end
    pulse_req(4'b0001);
    begin
      int i = 0;
      while (!(m_busy && m_id == 2 && m_seg == 6 && m_left == 1 && m_pre == P - 1) && i < 400) begin
        step(1); i++;
      end
      check("wait_final_gap", i < 400, 1);
    end
    pulse_req(4'b0100);
    step(400);
    check("replay_count", ndone, 3);
    check("replay_0", dq.size() > 0 ? dq[0] : -1, 2);
    check("replay_1", dq.size() > 1 ? dq[1] : -1, 0);
    check("replay_2", dq.size() > 2 ? dq[2] : -1, 2);

    do_reset();
    pulse_req(4'b1000);
    wait_led(50);
    step(2);
    clear_counts();
    en = 0;
    step(1);
    check("en_off_led", led, 0);
    check("en_off_busy", busy, 0);
    step(10);
    check("en_off_no_done", ndone, 0);
    en = 1;
    clear_counts();
    step(300);
    check("reen_done_count", ndone, 1);
    check("reen_id", dq.size() > 0 ? dq[0] : -1, 3);
    check("reen_led_cycles", nled, 32);

    do_reset();
    pulse_req(4'b0011);
    wait_led(50);
    step(1);
    rst = 1;
    #1;
    check("async_rst_led", led, 0);
    check("async_rst_busy", busy, 0);
    step(2);
    rst = 0;
    clear_counts();
    step(150);
    check("rst_cleared_pending", nled, 0);
    check("rst_no_done", ndone, 0);

    do_reset();
    repeat (4000) begin
      for (int b = 0; b < 4; b++) if ($urandom % 24 == 0) req[b] = ~req[b];
      if (en ? $urandom % 300 == 0 : $urandom % 20 == 0) en = ~en;
      force_on = $urandom % 12 == 0;
      if ($urandom % 1500 == 0) begin rst = 1; step(1); rst = 0; end
      step(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
